l2_port_scheduler: RTL and testbench

- Shares the single L2-facing line port between the instruction-cache miss path (A, read-only) and the data-cache miss path (B, read/write).
- Sits between the L1 caches and the L2 cache.
- Serialises 256-bit line transactions with a registered, non-preemptive grant.
- Data-side priority is bounded by a starvation limit, so instruction fetch misses always make progress.

---
 rtl/l2_port_scheduler.sv | 92 +++++++++
 tb/tb_l2_port_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_scheduler.sv
// Arbitrates the single L2 line port between the I-cache miss path (A) and the
// D-cache miss path (B); non-preemptive, with a starvation bound on B priority.
module l2_port_scheduler #(
    parameter int MAX_WAIT = 4,
    parameter int LINE_W   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read_a,
    input  logic [31:0]       pmem_addr_a,
    output logic              pmem_resp_a,
    output logic [LINE_W-1:0] pmem_rdata_a,
    input  logic              pmem_read_b,
    input  logic              pmem_write_b,
    input  logic [31:0]       pmem_addr_b,
    input  logic [LINE_W-1:0] pmem_wdata_b,
    output logic              pmem_resp_b,
    output logic [LINE_W-1:0] pmem_rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_A = 2'd1;
    localparam logic [1:0] BUSY_B = 2'd2;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [1:0] state;
    logic [3:0] count;
    logic       req_b;
    logic       grant_a;

    assign req_b   = pmem_read_b | pmem_write_b;
    // A wins outright when B is quiet, or when B has used up its priority budget.
    assign grant_a = pmem_read_a & (~req_b | (count == MAX_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 4'd0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 32'd0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a) begin
                        state       <= BUSY_A;
                        count       <= 4'd0;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= pmem_addr_a;
                    end else if (req_b) begin
                        state       <= BUSY_B;
                        mem_write   <= pmem_write_b;
                        mem_read    <= ~pmem_write_b;
                        mem_address <= pmem_addr_b;
                        mem_wdata   <= pmem_wdata_b;
                        if (!pmem_read_a)
                            count <= 4'd0;
                        else if (count != MAX_CNT)
                            count <= count + 4'd1;
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_resp_a  = mem_resp & (state == BUSY_A);
    assign pmem_resp_b  = mem_resp & (state == BUSY_B);
    assign pmem_rdata_a = mem_rdata;
    assign pmem_rdata_b = mem_rdata;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for l2_port_scheduler: single grants, fairness, non-preemption,
// asynchronous reset, stray L2 responses and requester drop.
module tb_l2_port_scheduler;

    localparam int W        = 256;
    localparam int MAX_WAIT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pmem_read_a = 1'b0;
    logic [31:0]  pmem_addr_a = '0;
    logic         pmem_resp_a;
    logic [W-1:0] pmem_rdata_a;
    logic         pmem_read_b = 1'b0;
    logic         pmem_write_b = 1'b0;
    logic [31:0]  pmem_addr_b = '0;
    logic [W-1:0] pmem_wdata_b = '0;
    logic         pmem_resp_b;
    logic [W-1:0] pmem_rdata_b;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [W-1:0] mem_wdata;
    logic         mem_resp = 1'b0;
    logic [W-1:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    l2_port_scheduler #(.MAX_WAIT(MAX_WAIT), .LINE_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_read_a(pmem_read_a), .pmem_addr_a(pmem_addr_a),
        .pmem_resp_a(pmem_resp_a), .pmem_rdata_a(pmem_rdata_a),
        .pmem_read_b(pmem_read_b), .pmem_write_b(pmem_write_b),
        .pmem_addr_b(pmem_addr_b), .pmem_wdata_b(pmem_wdata_b),
        .pmem_resp_b(pmem_resp_b), .pmem_rdata_b(pmem_rdata_b),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        assert (!(pmem_read_b && pmem_write_b)) else $error("illegal simultaneous B read and write");

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pat1;
        logic [W-1:0] pat2;
        logic [W-1:0] wpat;
        logic         exp_a;
        pat1 = {8{32'hDEAD_BEEF}};
        pat2 = {8{32'h1234_5678}};
        wpat = {32{8'hA5}};

        // Reset state
        repeat (2) tick();
        check("rst_mem_read",  W'(mem_read),    W'(0));
        check("rst_mem_write", W'(mem_write),   W'(0));
        check("rst_mem_addr",  W'(mem_address), W'(0));
        check("rst_mem_wdata", mem_wdata,       W'(0));
        check("rst_resp_a",    W'(pmem_resp_a), W'(0));
        check("rst_resp_b",    W'(pmem_resp_b), W'(0));
        rst_n = 1'b1;
        tick();

        // 1. A-only read
        pmem_read_a = 1'b1;
        pmem_addr_a = 32'h0000_1000;
        tick();
        check("a_mem_read",  W'(mem_read),    W'(1));
        check("a_mem_write", W'(mem_write),   W'(0));
        check("a_mem_addr",  W'(mem_address), W'(32'h1000));
        tick();
        tick();
        check("a_hold_read", W'(mem_read),    W'(1));
        check("a_hold_addr", W'(mem_address), W'(32'h1000));
        mem_rdata = pat1;
        mem_resp  = 1'b1;
        #1;
        check("a_resp_a",  W'(pmem_resp_a), W'(1));
        check("a_resp_b",  W'(pmem_resp_b), W'(0));
        check("a_rdata_a", pmem_rdata_a,    pat1);
        tick();
        mem_resp    = 1'b0;
        pmem_read_a = 1'b0;
        #1;
        check("a_resp_end", W'(pmem_resp_a), W'(0));
        check("a_read_end", W'(mem_read),    W'(0));

        // 2. B write
        tick();
        pmem_write_b = 1'b1;
        pmem_addr_b  = 32'h0000_2000;
        pmem_wdata_b = wpat;
        tick();
        check("bw_mem_write", W'(mem_write),   W'(1));
        check("bw_mem_read",  W'(mem_read),    W'(0));
        check("bw_mem_addr",  W'(mem_address), W'(32'h2000));
        check("bw_mem_wdata", mem_wdata,       wpat);
        tick();
        mem_resp = 1'b1;
        #1;
        check("bw_resp_b", W'(pmem_resp_b), W'(1));
        check("bw_resp_a", W'(pmem_resp_a), W'(0));
        tick();
        mem_resp     = 1'b0;
        pmem_write_b = 1'b0;
        #1;
        check("bw_resp_end",  W'(pmem_resp_b), W'(0));
        check("bw_write_end", W'(mem_write),   W'(0));

        // 3. Fairness with both requesting: B,B,B,B,A repeating
        tick();
        pmem_read_a = 1'b1;
        pmem_addr_a = 32'h0000_A000;
        pmem_read_b = 1'b1;
        pmem_addr_b = 32'h0000_B000;
        for (int i = 0; i < 10; i++) begin
            exp_a = ((i % 5) == 4);
            tick();
            check($sformatf("fair_addr_%0d", i), W'(mem_address),
                  exp_a ? W'(32'hA000) : W'(32'hB000));
            mem_resp = 1'b1;
            #1;
            check($sformatf("fair_resp_a_%0d", i), W'(pmem_resp_a), W'(exp_a));
            tick();
            mem_resp = 1'b0;
            if (i == 9) begin
                pmem_read_a = 1'b0;
                pmem_read_b = 1'b0;
            end
        end

        // 4. Non-preemption: A arrives while BUSY_B
        tick();
        pmem_read_b = 1'b1;
        pmem_addr_b = 32'h0000_3000;
        tick();
        check("np_b_read", W'(mem_read),    W'(1));
        check("np_b_addr", W'(mem_address), W'(32'h3000));
        pmem_read_a = 1'b1;
        pmem_addr_a = 32'h0000_4000;
        tick();
        check("np_hold1", W'(mem_address), W'(32'h3000));
        tick();
        check("np_hold2", W'(mem_address), W'(32'h3000));
        mem_rdata = pat2;
        mem_resp  = 1'b1;
        #1;
        check("np_resp_b",  W'(pmem_resp_b), W'(1));
        check("np_resp_a",  W'(pmem_resp_a), W'(0));
        check("np_rdata_b", pmem_rdata_b,    pat2);
        tick();
        mem_resp    = 1'b0;
        pmem_read_b = 1'b0;
        tick();
        check("np_a_addr", W'(mem_address), W'(32'h4000));
        check("np_a_read", W'(mem_read),    W'(1));
        mem_resp = 1'b1;
        #1;
        check("np_a_resp", W'(pmem_resp_a), W'(1));
        tick();
        mem_resp    = 1'b0;
        pmem_read_a = 1'b0;

        // 5. Reset during BUSY_A
        tick();
        pmem_read_a = 1'b1;
        pmem_addr_a = 32'h0000_5000;
        tick();
        check("rs_read_before", W'(mem_read), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_read_async", W'(mem_read),    W'(0));
        check("rs_addr_async", W'(mem_address), W'(0));
        tick();
        pmem_read_a = 1'b0;
        pmem_read_b = 1'b1;
        pmem_addr_b = 32'h0000_6000;
        rst_n       = 1'b1;
        tick();
        check("rs_b_addr", W'(mem_address), W'(32'h6000));
        check("rs_b_read", W'(mem_read),    W'(1));
        mem_resp = 1'b1;
        #1;
        check("rs_b_resp", W'(pmem_resp_b), W'(1));
        tick();
        mem_resp    = 1'b0;
        pmem_read_b = 1'b0;

        // 6a. Stray mem_resp in IDLE
        tick();
        mem_resp = 1'b1;
        #1;
        check("stray_resp_a", W'(pmem_resp_a), W'(0));
        check("stray_resp_b", W'(pmem_resp_b), W'(0));
        tick();
        mem_resp = 1'b0;
        check("stray_read",  W'(mem_read),  W'(0));
        check("stray_write", W'(mem_write), W'(0));

        // 6b. A drops its request mid-transaction
        tick();
        pmem_read_a = 1'b1;
        pmem_addr_a = 32'h0000_7000;
        tick();
        pmem_read_a = 1'b0;
        tick();
        check("drop_read_held", W'(mem_read),    W'(1));
        check("drop_addr_held", W'(mem_address), W'(32'h7000));
        mem_resp = 1'b1;
        #1;
        check("drop_resp_a", W'(pmem_resp_a), W'(1));
        tick();
        mem_resp = 1'b0;
        #1;
        check("drop_read_end", W'(mem_read), W'(0));
        tick();
        check("drop_no_regrant", W'(mem_read), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
